// File: rtl/upc_tag_tx_if.sv
// Tag/price-entry side of the UPC serial link: request, code, mark, and
// the serial line with its status outputs.
interface upc_tag_tx_if;
    logic       start;
    logic [2:0] upc;
    logic       mark;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] frame_count;

    modport master (
        output start, upc, mark,
        input  tx, busy, done, frame_count
    );

    modport slave (
        input  start, upc, mark,
        output tx, busy, done, frame_count
    );
endinterface

// File: rtl/upc_tag_tx.sv
// Serializes a latched UPC code plus secret-mark bit as a framed,
// even-parity bit stream: start, U, P, C, mark, parity, stop.
//
// state    | meaning
// S_IDLE   | line idle high, waiting for start
// S_START  | start bit (0)
// S_DATA   | U, P, C, mark, MSB first
// S_PARITY | U^P^C^mark
// S_STOP   | stop bit (1), then done pulse on return to idle
module upc_tag_tx #(
    parameter int CLKS_PER_BIT = 50
) (
    input  logic           clk,
    input  logic           reset_n,
    upc_tag_tx_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] LP_BIT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    logic [15:0] r_timer;
    logic [1:0]  r_idx;
    logic [3:0]  r_shift;
    logic        r_parity;
    logic        r_done;
    logic [7:0]  r_frame_count;

    state_t      w_state_nxt;
    logic [15:0] w_timer_nxt;
    logic [1:0]  w_idx_nxt;
    logic [3:0]  w_shift_nxt;
    logic        w_parity_nxt;
    logic        w_done_nxt;
    logic [7:0]  w_count_nxt;
    logic        w_bit_end;
    logic        w_tx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_timer       <= 16'd0;
            r_idx         <= 2'd0;
            r_shift       <= 4'd0;
            r_parity      <= 1'b0;
            r_done        <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_idx         <= w_idx_nxt;
            r_shift       <= w_shift_nxt;
            r_parity      <= w_parity_nxt;
            r_done        <= w_done_nxt;
            r_frame_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_done_nxt   = 1'b0;
        w_count_nxt  = r_frame_count;
        w_bit_end    = (r_timer == 16'd0);

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt  = S_START;
                    w_timer_nxt  = LP_BIT_LAST;
                    w_idx_nxt    = 2'd0;
                    w_shift_nxt  = {bus.upc, bus.mark};
                    w_parity_nxt = ^{bus.upc, bus.mark};
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_timer_nxt = LP_BIT_LAST;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_timer_nxt = LP_BIT_LAST;
                    w_shift_nxt = {r_shift[2:0], 1'b0};
                    if (r_idx == 2'd3) begin
                        w_state_nxt = S_PARITY;
                        w_idx_nxt   = 2'd0;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_timer_nxt = LP_BIT_LAST;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_STOP: begin
                // done and the count update land on the same edge as the return to idle
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_count_nxt = r_frame_count + 8'd1;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // tx decodes from registered state only, so start never reaches the line combinationally
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_IDLE:   w_tx = 1'b1;
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = r_shift[3];
            S_PARITY: w_tx = r_parity;
            S_STOP:   w_tx = 1'b1;
            default:  w_tx = 1'b1;
        endcase
    end

    assign bus.tx          = w_tx;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_upc_tag_tx.sv
// Directed bench for upc_tag_tx: one instance at 4 clocks/bit for frame
// content and boundary cases, one at 1 clock/bit for the counter wrap.
module tb_upc_tag_tx;

    logic clk;
    logic reset_n;

    int n_cmp;
    int n_err;

    upc_tag_tx_if if4();
    upc_tag_tx_if if1();

    upc_tag_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if4.slave)
    );

    upc_tag_tx #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Caller is 1 ns after a rising edge. Returns in the done cycle.
    task automatic frame4(input string tag, input logic [2:0] u, input logic m,
                          input logic [6:0] exp_bits, input logic [7:0] exp_count,
                          input bit hold, input int inj_cycle);
        logic [27:0] rec;
        int          busy_cnt;
        logic [3:0]  obs;
        if4.upc   = u;
        if4.mark  = m;
        if4.start = 1'b1;
        @(posedge clk); #1;
        if (!hold) if4.start = 1'b0;
        busy_cnt = 0;
        rec      = '0;
        for (int c = 0; c < 28; c++) begin
            rec[c]   = if4.tx;
            busy_cnt += int'(if4.busy);
            if (c == inj_cycle) begin
                if4.upc   = 3'b111;
                if4.mark  = 1'b1;
                if4.start = 1'b1;
            end
            if (c == inj_cycle + 1) if4.start = 1'b0;
            @(posedge clk); #1;
        end
        for (int b = 0; b < 7; b++) begin
            obs = rec[b*4 +: 4];
            check($sformatf("%s.bit%0d", tag, b), 32'(obs), exp_bits[6-b] ? 32'hF : 32'h0);
        end
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 28);
        check({tag, ".done"}, 32'(if4.done), 1);
        check({tag, ".busy_end"}, 32'(if4.busy), 0);
        check({tag, ".tx_gap"}, 32'(if4.tx), 1);
        check({tag, ".count"}, 32'(if4.frame_count), 32'(exp_count));
    endtask

    initial begin
        logic [6:0] rec7;
        int         busy_cnt;
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        if4.start = 1'b0; if4.upc = 3'b000; if4.mark = 1'b0;
        if1.start = 1'b0; if1.upc = 3'b000; if1.mark = 1'b0;

        #2;
        check("rst.tx",    32'(if4.tx), 1);
        check("rst.busy",  32'(if4.busy), 0);
        check("rst.done",  32'(if4.done), 0);
        check("rst.count", 32'(if4.frame_count), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle.tx", 32'(if4.tx), 1);

        frame4("basic", 3'b101, 1'b0, 7'b0101001, 8'd1, 1'b0, -1);
        @(posedge clk); #1;
        check("basic.done_1cyc", 32'(if4.done), 0);

        frame4("parity", 3'b011, 1'b1, 7'b0011111, 8'd2, 1'b0, -1);
        @(posedge clk); #1;

        frame4("reject", 3'b100, 1'b0, 7'b0100011, 8'd3, 1'b0, 10);
        repeat (3) begin
            @(posedge clk); #1;
            check("reject.no_second", 32'(if4.busy), 0);
        end
        check("reject.count", 32'(if4.frame_count), 3);

        frame4("b2b_a", 3'b110, 1'b1, 7'b0110111, 8'd4, 1'b1, -1);
        frame4("b2b_b", 3'b110, 1'b1, 7'b0110111, 8'd5, 1'b0, -1);
        @(posedge clk); #1;
        check("b2b.done_1cyc", 32'(if4.done), 0);

        if4.upc   = 3'b101;
        if4.mark  = 1'b0;
        if4.start = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst.busy_before", 32'(if4.busy), 1);
        reset_n = 1'b0;
        #1;
        check("midrst.tx",    32'(if4.tx), 1);
        check("midrst.busy",  32'(if4.busy), 0);
        check("midrst.done",  32'(if4.done), 0);
        check("midrst.count", 32'(if4.frame_count), 0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        frame4("fresh", 3'b101, 1'b0, 7'b0101001, 8'd1, 1'b0, -1);
        @(posedge clk); #1;

        if1.upc   = 3'b010;
        if1.mark  = 1'b1;
        if1.start = 1'b1;
        for (int f = 1; f <= 256; f++) begin
            @(posedge clk); #1;
            busy_cnt = 0;
            for (int c = 0; c < 7; c++) begin
                rec7[6-c] = if1.tx;
                busy_cnt += int'(if1.busy);
                @(posedge clk); #1;
            end
            if (f == 1) begin
                check("wrap.bits", 32'(rec7), 32'(7'b0010101));
                check("wrap.count1", 32'(if1.frame_count), 1);
            end
            if (f == 1 || f == 128 || f == 256)
                check($sformatf("wrap.busy%0d", f), 32'(busy_cnt), 7);
            if (f == 255) check("wrap.count255", 32'(if1.frame_count), 255);
            if (f == 256) begin
                check("wrap.count0", 32'(if1.frame_count), 0);
                check("wrap.done", 32'(if1.done), 1);
            end
        end
        if1.start = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
